// File: rtl/output_buffer.sv
// output_buffer: DEPTH-entry FWFT queue with valid/ready read, occupancy and sticky overflow.
// Define OUTPUT_BUFFER_BYPASS_EN for a zero-latency empty-queue write-to-read path.
module output_buffer #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 4,
    parameter int HOLD_LAST = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     Write_En,
    input  logic [DWIDTH-1:0]        Write_Data,
    output logic                     Write_Ready,
    output logic                     Read_Valid,
    input  logic                     Read_Ready,
    output logic [DWIDTH-1:0]        Read_Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow_Err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] last;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              byp, push, pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

`ifdef OUTPUT_BUFFER_BYPASS_EN
    assign byp = Empty & Write_En & Read_Ready;
`else
    assign byp = 1'b0;
`endif

    assign Full        = Count == CW'(DEPTH);
    assign Empty       = Count == '0;
    assign Write_Ready = !Full | Read_Ready;
    assign Read_Valid  = !Empty | byp;
    assign pop         = !Empty & Read_Ready;
    assign push        = Write_En & Write_Ready & !byp;
    assign Read_Data   = byp ? Write_Data : !Empty ? mem[rd_ptr] : HOLD_LAST != 0 ? last : '0;

    always_ff @(posedge Clk) begin
        if (push & !Reset & !Clear)
            mem[wr_ptr] <= Write_Data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Overflow_Err <= 1'b0;
            last         <= '0;
        end else if (Clear) begin
            Count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Overflow_Err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= inc(wr_ptr);
            if (pop)
                rd_ptr <= inc(rd_ptr);
            Count        <= push & !pop ? Count + CW'(1) : pop & !push ? Count - CW'(1) : Count;
            Overflow_Err <= Overflow_Err | (Write_En & !Write_Ready);
            // bypassed words count as popped for the hold register
            if (HOLD_LAST != 0 && (pop || byp))
                last <= byp ? Write_Data : mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: directed steps against a queue scoreboard for output_buffer (DEPTH=4, HOLD_LAST=1).
module tb_output_buffer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0, Clear = 1'b0, Write_En = 1'b0, Read_Ready = 1'b0;
    logic [31:0] Write_Data = '0;
    logic        Write_Ready, Read_Valid, Full, Empty, Overflow_Err;
    logic [31:0] Read_Data;
    logic [2:0]  Count;
    int          checks = 0, errors = 0;
    logic [31:0] q[$];
    logic [31:0] last = '0;
    logic        ovf = 1'b0;
    bit          bypass_build;

    output_buffer #(.DWIDTH(32), .DEPTH(4), .HOLD_LAST(1)) dut (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .Write_En(Write_En), .Write_Data(Write_Data),
        .Write_Ready(Write_Ready), .Read_Valid(Read_Valid), .Read_Ready(Read_Ready),
        .Read_Data(Read_Data), .Count(Count), .Full(Full), .Empty(Empty), .Overflow_Err(Overflow_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs at negedge, update model, check state after the edge.
    task automatic step(input logic we, input logic [31:0] wd, input logic rr, input logic clr);
        logic byp, wr_ok;
        Write_En = we; Write_Data = wd; Read_Ready = rr; Clear = clr;
        @(negedge Clk);
        byp   = bypass_build && q.size() == 0 && we && rr;
        wr_ok = q.size() < 4 || rr;
        check("read_valid", {31'd0, Read_Valid}, {31'd0, q.size() != 0 || byp});
        check("read_data", Read_Data, byp ? wd : q.size() != 0 ? q[0] : last);
        check("write_ready", {31'd0, Write_Ready}, {31'd0, wr_ok});
        if (clr) begin
            q.delete();
            ovf = 1'b0;
        end else if (byp) begin
            last = wd;
        end else begin
            if (q.size() != 0 && rr)
                last = q.pop_front();
            if (we) begin
                if (wr_ok) q.push_back(wd);
                else ovf = 1'b1;
            end
        end
        @(posedge Clk);
        #1;
        check("count", {29'd0, Count}, q.size());
        check("full", {31'd0, Full}, {31'd0, q.size() == 4});
        check("empty", {31'd0, Empty}, {31'd0, q.size() == 0});
        check("overflow", {31'd0, Overflow_Err}, {31'd0, ovf});
    endtask

    initial begin
`ifdef OUTPUT_BUFFER_BYPASS_EN
        bypass_build = 1'b1;
`else
        bypass_build = 1'b0;
`endif
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("reset_count", {29'd0, Count}, 32'd0);
        check("reset_empty", {31'd0, Empty}, 32'd1);
        check("reset_valid", {31'd0, Read_Valid}, 32'd0);
        check("reset_data", Read_Data, 32'd0);
        check("reset_ovf", {31'd0, Overflow_Err}, 32'd0);
        step(0, 0, 0, 0);

        for (int i = 1; i <= 4; i++) step(1, 32'hA0 + i, 0, 0);
        check("fill_full", {31'd0, Full}, 32'd1);
        check("fill_count", {29'd0, Count}, 32'd4);
        check("fill_head", Read_Data, 32'hA1);
        step(1, 32'hA5, 0, 0);
        check("ovf_set", {31'd0, Overflow_Err}, 32'd1);
        check("ovf_count", {29'd0, Count}, 32'd4);

        step(1, 32'hB0, 1, 0);
        check("full_rw_count", {29'd0, Count}, 32'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        check("drain_empty", {31'd0, Empty}, 32'd1);
        check("hold_last", Read_Data, 32'hB0);

        for (int i = 0; i < 10; i++) begin
            step(1, i, 1, 0);
            check("stream_count_le1", {31'd0, Count <= 3'd1}, 32'd1);
        end
        step(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 32'hC0 + i, 0, 0);
        check("pre_clear_count", {29'd0, Count}, 32'd3);
        check("pre_clear_ovf", {31'd0, Overflow_Err}, 32'd1);
        step(1, 32'hCC, 0, 1);
        check("clear_count", {29'd0, Count}, 32'd0);
        check("clear_ovf", {31'd0, Overflow_Err}, 32'd0);
        step(0, 0, 0, 0);
        check("clear_discard", {31'd0, Read_Valid}, 32'd0);

        Write_En = 1'b1; Write_Data = 32'h5A; Read_Ready = 1'b1;
        #1;
        check("byp_same_valid", {31'd0, Read_Valid}, {31'd0, bypass_build});
        step(1, 32'h5A, 1, 0);
        step(0, 0, 0, 0);
        if (bypass_build) begin
            check("byp_next_count", {29'd0, Count}, 32'd0);
            check("byp_next_data", Read_Data, 32'h5A);
        end else begin
            check("nobyp_next_valid", {31'd0, Read_Valid}, 32'd1);
            check("nobyp_next_data", Read_Data, 32'h5A);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        check("final_empty", {31'd0, Empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Parametrised successor to the single-entry PE output register in the CGRA.
- Provides a DEPTH-entry first-word-fall-through queue with a valid/ready read handshake, occupancy reporting, and overflow detection.
- Sits at the PE result output. Decouples PE write timing from interconnect/consumer readiness.
- With DEPTH=1 and Read_Ready tied high, it degenerates to the old register behaviour, plus a valid flag.

Parameters:
- DWIDTH, 32, data width in bits.
- DEPTH, 4, number of entries. Power of two, ≥1. DEPTH=1 is legal.
- HOLD_LAST, 1, 1: Read_Data holds the last popped word while empty. 0: Read_Data = 0 while empty.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Clear  input  1  synchronous flush. Empties the queue and clears Overflow_Err; storage contents are not cleared.
- Write_En  input  1  producer write request.
- Write_Data  input  DWIDTH  producer data.
- Write_Ready  output  1  high when a write this cycle will be accepted.
- Read_Valid  output  1  head entry valid.
- Read_Ready  input  1  consumer accepts head this cycle.
- Read_Data  output  DWIDTH  head entry (FWFT).
- Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Full  output  1  Count==DEPTH.
- Empty  output  1  Count==0.
- Overflow_Err  output  1  sticky: a write was attempted while Write_Ready=0.

Behaviour:
- Reset (synchronous, active-high, Clk only), effective on the next edge:
  - Count=0, read/write pointers=0, Empty=1, Full=0, Read_Valid=0, Overflow_Err=0.
  - Read_Data=0 and the last-popped register is 0.
  - Storage array is not reset.
- Reset has priority over Clear; Clear has priority over push/pop. Reset or Clear mid-operation discards all entries; no pop or push occurs that cycle.
- Definitions:
  - pop = Read_Valid & Read_Ready.
  - Write_Ready = !Full | Read_Ready. A full queue accepts a write when the head is popped in the same cycle.
  - push = Write_En & Write_Ready.
- Push: Write_Data is stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH. Under HOLD_LAST=1 the popped word is copied to the last-popped register.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Pointer wrap-around is natural modulo DEPTH. Full/Empty are derived from Count, never from pointer equality.
- Latency:
  - Write_En at edge N → Read_Valid=1 and Read_Data=Write_Data after edge N (1 cycle).
  - Read_Data is combinational from storage[rd_ptr] (FWFT, no read latency).
- Read_Valid = !Empty.
- When Empty: Read_Data = last-popped register if HOLD_LAST=1, else 0.
- Read_Ready while Empty is ignored; no underflow and no state change.
- Overflow:
  - Write_En=1 while Write_Ready=0 drops the data and sets Overflow_Err at the next edge.
  - Overflow_Err stays set until Clear or Reset.
  - Count and contents are unaffected.
- Throughput: one push and one pop per cycle, sustained, at any occupancy including Full.
- DEPTH=1: pointers are constant 0 and Count is 1 bit wide + 1. The same rules apply.

Optional Feature:
- Macro OUTPUT_BUFFER_BYPASS_EN.
- Defined: when Empty=1, Write_En=1 and Read_Ready=1 in the same cycle:
  - Read_Valid=1 and Read_Data=Write_Data combinationally (0-cycle latency).
  - The word is consumed without being stored; Count stays 0 and pointers are unchanged.
  - The last-popped register is updated with Write_Data under HOLD_LAST=1.
  - In all other cycles, behaviour is unchanged.
- Undefined: no combinational Write→Read path. An empty-queue write always takes 1 cycle to appear, and the same-cycle Read_Ready has no effect.

Test Plan:
- Reset=1 two cycles, then idle → Count=0, Empty=1, Read_Valid=0, Read_Data=0, Overflow_Err=0.
- DEPTH=4, Read_Ready=0, write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles → Full=1, Count=4, Read_Data=0xA1. Then a fifth write 0xA5 → Write_Ready=0, Overflow_Err=1, Count=4.
- Full queue, Read_Ready=1 and write 0xB0 the same cycle → Count stays 4. Subsequent pops yield 0xA2,0xA3,0xA4,0xB0, then Empty=1 and Read_Data=0xB0 (HOLD_LAST=1).
- Continuous write/read for 10 words 0x00..0x09 with Read_Ready=1 → each word valid exactly 1 cycle after its write, order preserved across pointer wrap, Count never exceeds 1.
- Queue holds 3 entries with Overflow_Err=1; assert Clear with Write_En=1 the same cycle → next cycle Count=0, Empty=1, Overflow_Err=0, written word discarded.
- With OUTPUT_BUFFER_BYPASS_EN, empty queue, Write_En=1, Write_Data=0x5A, Read_Ready=1 → same cycle Read_Valid=1, Read_Data=0x5A; next cycle Count=0. Without the macro → Read_Valid=0 that cycle, Read_Valid=1 and Read_Data=0x5A next cycle.
